// File: rtl/mag_power_ctrl_pkg.sv
// Shared definitions for the magnetron power controller: FSM state encoding,
// default timing constants and a counter-width helper.
package mag_power_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_MAX_LEVEL   = 10;
  localparam int DEF_SLOT_CYCLES = 100;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mag_duty_gen.sv
// Power-period timebase: cycles within a slot and slot index within a period.
// restart clears both counters and wins over run; otherwise they hold.
module mag_duty_gen
  import mag_power_ctrl_pkg::*;
#(
  parameter int  MAX_LEVEL   = DEF_MAX_LEVEL,
  parameter int  SLOT_CYCLES = DEF_SLOT_CYCLES,
  localparam int SLOT_W      = cnt_w(MAX_LEVEL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              restart,
  output logic [SLOT_W-1:0] slot_idx
);

  localparam int CYC_W = cnt_w(SLOT_CYCLES);

  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  always_comb begin
    cyc_d  = cyc_q;
    slot_d = slot_q;
    if (restart) begin
      cyc_d  = '0;
      slot_d = '0;
    end else if (run) begin
      if (cyc_q == CYC_W'(SLOT_CYCLES - 1)) begin
        cyc_d  = '0;
        slot_d = (slot_q == SLOT_W'(MAX_LEVEL - 1)) ? '0 : slot_q + SLOT_W'(1);
      end else begin
        cyc_d = cyc_q + CYC_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q  <= '0;
      slot_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      slot_q <= slot_d;
    end
  end

  assign slot_idx = slot_q;

endmodule

// File: rtl/mag_power_ctrl.sv
// Magnetron enable controller: cook/pause/done/clear FSM, latched power level
// and slot-based duty cycling, with a combinational door interlock on mag_on.
module mag_power_ctrl
  import mag_power_ctrl_pkg::*;
#(
  parameter int LEVEL_W     = 4,
  parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
  parameter int SLOT_CYCLES = DEF_SLOT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               startn,
  input  logic               stopn,
  input  logic               clrn,
  input  logic               door_closed,
  input  logic               timer_done,
  input  logic [LEVEL_W-1:0] power_level,
  output logic               mag_on,
  output logic               cooking,
  output logic               paused,
  output logic               done
);

  localparam int SLOT_W = cnt_w(MAX_LEVEL);
  localparam int PWR_W  = $clog2(MAX_LEVEL + 1);
  localparam int CMP_W  = (LEVEL_W > PWR_W) ? LEVEL_W : PWR_W;

  state_e             state_q, state_d;
  logic [PWR_W-1:0]   pwr_q, pwr_d;
  logic               startn_q;
  logic               armed_q;
  logic               start_evt, start_ok;
  logic [CMP_W-1:0]   lvl_ext, max_ext;
  logic [PWR_W-1:0]   lvl_clamped;
  logic [SLOT_W-1:0]  slot_idx;
  logic               run, restart;

  // armed_q masks the first cycle after reset so a button held low through
  // reset cannot look like a fresh falling edge.
  assign start_evt = armed_q && startn_q && !startn;
  assign start_ok  = start_evt && door_closed && stopn && clrn && !timer_done;

  assign lvl_ext     = CMP_W'(power_level);
  assign max_ext     = CMP_W'(MAX_LEVEL);
  assign lvl_clamped = (lvl_ext > max_ext) ? PWR_W'(max_ext) : PWR_W'(lvl_ext);

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pwr_d   = pwr_q;
    if (!clrn) begin
      state_d = ST_IDLE;
      pwr_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok && power_level != '0) begin
            state_d = ST_COOK;
            pwr_d   = lvl_clamped;
          end
        end
        ST_COOK: begin
          if (timer_done)                  state_d = ST_DONE;
          else if (!door_closed || !stopn) state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (timer_done)    state_d = ST_DONE;
          else if (start_ok) state_d = ST_COOK;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Counters restart on each entry to COOK and sit at zero in IDLE/DONE.
  assign run     = (state_q == ST_COOK);
  assign restart = (state_d == ST_COOK && state_q != ST_COOK) ||
                   (state_d == ST_IDLE) || (state_d == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pwr_q    <= '0;
      startn_q <= 1'b1;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwr_q    <= pwr_d;
      startn_q <= startn;
      armed_q  <= 1'b1;
    end
  end

  mag_duty_gen #(
    .MAX_LEVEL   (MAX_LEVEL),
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_duty (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .restart  (restart),
    .slot_idx (slot_idx)
  );

  assign mag_on  = (state_q == ST_COOK) && (PWR_W'(slot_idx) < pwr_q) && door_closed;
  assign cooking = (state_q == ST_COOK);
  assign paused  = (state_q == ST_PAUSE);
  assign done    = (state_q == ST_DONE);

endmodule
